fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/fifo_drain_skid.sv | 55 +++++
 rtl/fifo_drain.sv | 118 +++++++++++
 tb/tb_fifo_drain.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain engine: FSM states, counter width, defaults.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int CNT_W         = 16;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_FRAME_LEN = 4;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer holding data plus frame-last tag; push lands next cycle,
// head is presented combinationally and only moves on pop (stable under backpressure).
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] tail_data;
    logic             tail_last;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            if (pop) begin
                if (count == 2'd2) begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    if (push) begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                end else if (push) begin
                    head_data <= push_data;
                    head_last <= push_last;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_data <= push_data;
                    head_last <= push_last;
                end else begin
                    tail_data <= push_data;
                    tail_last <= push_last;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream FIFO into a valid/ready stream framed in FRAME_LEN-word frames.
// fifo_read -> m_valid takes 2 cycles; reads are throttled so buffer plus in-flight never exceeds 2.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_write,
    output logic             fifo_read,
    input  logic             drain_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] issue_beat;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        count;
    logic [WIDTH-1:0]  head_data;
    logic              head_last;
    logic              pop;
    logic              rd_acc;
    logic              frame_boundary;
    logic [2:0]        occupancy;

    assign m_valid        = (count != 2'd0);
    assign m_data         = head_data;
    assign m_last         = head_last && m_valid;
    assign pop            = m_valid && m_ready;
    assign frame_boundary = (issue_beat == '0);
    // Slots already committed after this cycle's pop; a new read needs one free.
    assign occupancy      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    // Upstream gives a simultaneous write priority, so such a read returns nothing.
    assign rd_acc         = fifo_read && !(fifo_write && !fifo_full);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (drain_en) state_nxt = ST_RUN;
            ST_RUN:    if (!drain_en) state_nxt = ST_FINISH;
            ST_FINISH: begin
                if (drain_en) begin
                    state_nxt = ST_RUN;
                end else if (frame_boundary && (count == 2'd0) && !inflight) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        fifo_read = rst_ && busy && !fifo_empty && (occupancy < 3'd2) &&
                    !((state == ST_FINISH) && frame_boundary);
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            issue_beat    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            word_cnt      <= '0;
            frame_cnt     <= '0;
        end else begin
            inflight <= rd_acc;
            if (rd_acc) begin
                inflight_last <= (issue_beat == LAST_BEAT);
                issue_beat    <= (issue_beat == LAST_BEAT) ? '0 : issue_beat + BEAT_W'(1);
            end
            if (pop) begin
                word_cnt <= word_cnt + CNT_W'(1);
                if (m_last) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    fifo_drain_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_     (rst_),
        .push     (inflight),
        .push_data(fifo_data_out),
        .push_last(inflight_last),
        .pop      (pop),
        .head_data(head_data),
        .head_last(head_last),
        .count    (count)
    );

endmodule

// File: tb/tb_fifo_drain.sv
// Randomised bench: upstream FIFO and expected stream kept as queues, every pop scored in order.
module tb_fifo_drain;

    localparam int WIDTH = 16;
    localparam int FL    = 4;
    localparam int DEPTH = 1 << 17;

    logic             clk = 1'b0;
    logic             rst_;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_write;
    logic             fifo_read;
    logic             drain_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [15:0]      word_cnt;
    logic [15:0]      frame_cnt;
    logic             busy;

    always #5 clk = ~clk;

    fifo_drain #(.WIDTH(WIDTH), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_write   (fifo_write),
        .fifo_read    (fifo_read),
        .drain_en     (drain_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .word_cnt     (word_cnt),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] up_q[$];
    logic [15:0] exp_q[$];
    int          pop_cyc[$];
    logic [15:0] next_word;
    int          mdl_words, mdl_frames, rd_cnt, rej_cnt, wr_tot, cyc;
    logic        stalled_prev;
    logic [15:0] hold_data;
    logic        hold_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO model plus per-pop scoreboard; inputs change at posedge+1.
    task automatic monitor();
        logic        rd_acc;
        logic        wr_acc;
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            cyc++;
            wr_acc = fifo_write && !fifo_full;
            rd_acc = 1'b0;
            if (!rst_) begin
                chk("read_in_reset", fifo_read, 0);
                stalled_prev = 1'b0;
            end else begin
                if (fifo_read) chk("read_when_empty", fifo_empty, 0);
                rd_acc = fifo_read && !fifo_empty && !wr_acc;
                if (fifo_read && !fifo_empty && wr_acc) rej_cnt++;
                if (m_valid) begin
                    if (stalled_prev) begin
                        chk("stall_data", m_data, hold_data);
                        chk("stall_last", m_last, hold_last);
                    end
                    if (m_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL extra_word: got 0x%0h, expected no word (t=%0t)", m_data, $time);
                        end else begin
                            exp_w = exp_q.pop_front();
                            chk("data", m_data, exp_w);
                            chk("last", m_last, (mdl_words % FL) == FL - 1);
                            chk("word_cnt", word_cnt, mdl_words & 32'hFFFF);
                            chk("frame_cnt", frame_cnt, mdl_frames & 32'hFFFF);
                            if ((mdl_words % FL) == FL - 1) mdl_frames++;
                            mdl_words++;
                            pop_cyc.push_back(cyc);
                        end
                    end
                end
                stalled_prev = m_valid && !m_ready;
                hold_data    = m_data;
                hold_last    = m_last;
            end
            @(posedge clk);
            #1;
            if (rd_acc && up_q.size() > 0) begin
                fifo_data_out = up_q.pop_front();
                rd_cnt++;
            end
            if (wr_acc) begin
                up_q.push_back(next_word);
                exp_q.push_back(next_word);
                next_word++;
                wr_tot++;
            end
            fifo_empty = (up_q.size() == 0);
            fifo_full  = (up_q.size() >= DEPTH);
        end
    endtask

    task automatic flush();
        up_q.delete();
        exp_q.delete();
        pop_cyc.delete();
        fifo_empty   = 1'b1;
        fifo_full    = 1'b0;
        next_word    = 16'h0001;
        mdl_words    = 0;
        mdl_frames   = 0;
        rd_cnt       = 0;
        rej_cnt      = 0;
        wr_tot       = 0;
        stalled_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst_       = 1'b0;
        drain_en   = 1'b0;
        m_ready    = 1'b0;
        fifo_write = 1'b0;
        @(posedge clk);
        #2;
        flush();
        rst_ = 1'b1;
    endtask

    task automatic preload(input int n);
        drain_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            fifo_write = 1'b1;
            @(posedge clk);
            #2;
        end
        fifo_write = 1'b0;
    endtask

    task automatic wait_words(input string name, input int n, input int budget);
        int c = 0;
        while (mdl_words < n && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk(name, mdl_words, n);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        rst_          = 1'b0;
        drain_en      = 1'b0;
        m_ready       = 1'b0;
        fifo_write    = 1'b0;
        fifo_data_out = '0;
        cyc           = 0;
        hold_data     = '0;
        hold_last     = 1'b0;
        flush();
        fork
            monitor();
        join_none

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst_ = 1'b1;

        // 8 words, full throughput
        preload(8);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        wait_words("s1_words", 8, 100);
        chk("s1_word_cnt", word_cnt, 8);
        chk("s1_frame_cnt", frame_cnt, 2);
        chk("s1_pops_seen", pop_cyc.size(), 8);
        if (pop_cyc.size() >= 8) chk("s1_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
        drain_en = 1'b0;
        wait_idle("s1_idle", 50);

        // m_ready toggling
        do_reset();
        preload(8);
        drain_en = 1'b1;
        for (int i = 0; i < 200 && mdl_words < 8; i++) begin
            m_ready = ~m_ready;
            @(posedge clk);
            #2;
        end
        chk("s2_words", mdl_words, 8);
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("s2_word_cnt", word_cnt, 8);
        chk("s2_frame_cnt", frame_cnt, 2);
        drain_en = 1'b0;
        wait_idle("s2_idle", 50);

        // Random writes colliding with reads, random backpressure
        do_reset();
        preload(8);
        drain_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            m_ready    = ($urandom_range(0, 3) != 0);
            fifo_write = (wr_tot < 40) && !fifo_full && ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #2;
        end
        fifo_write = 1'b0;
        m_ready    = 1'b1;
        wait_words("s3_words", 40, 200);
        chk("s3_word_cnt", word_cnt, 40);
        chk("s3_frame_cnt", frame_cnt, 10);
        chk("s3_rejected_reads_seen", rej_cnt > 0, 1);
        drain_en = 1'b0;
        wait_idle("s3_idle", 50);

        // drain_en dropped after the 2nd read of a frame
        do_reset();
        preload(8);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 50 && rd_cnt < 2; i++) begin
            @(posedge clk);
            #2;
        end
        chk("s4_reads_before_drop", rd_cnt, 2);
        drain_en = 1'b0;
        wait_idle("s4_idle", 50);
        repeat (5) @(posedge clk);
        #2;
        chk("s4_words", mdl_words, 4);
        chk("s4_frame_cnt", frame_cnt, 1);
        chk("s4_left_upstream", up_q.size(), 4);

        // Reset with two words buffered
        do_reset();
        preload(8);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        wait_words("s5_words", 3, 50);
        m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("s5_word_cnt", word_cnt, 3);
        chk("s5_held_valid", m_valid, 1);
        rst_     = 1'b0;
        drain_en = 1'b0;
        @(posedge clk);
        #2;
        chk("s5_m_valid", m_valid, 0);
        chk("s5_word_cnt_clr", word_cnt, 0);
        chk("s5_frame_cnt_clr", frame_cnt, 0);
        chk("s5_busy", busy, 0);
        flush();
        rst_ = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("s5_no_output_after", m_valid, 0);

        // word_cnt wrap after 65536 pops
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            up_q.push_back(next_word);
            exp_q.push_back(next_word);
            next_word++;
        end
        fifo_empty = 1'b0;
        drain_en   = 1'b1;
        m_ready    = 1'b1;
        wait_words("s6_words", 65536, 70000);
        chk("s6_word_cnt_wrap", word_cnt, 0);
        chk("s6_frame_cnt", frame_cnt, 16'h4000);
        drain_en = 1'b0;
        wait_idle("s6_idle", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
